fetch_sequencer: RTL and testbench

- Drives the program counter's control side: produces pc_next, PCen and stall from the current pc, the instruction-memory handshake and the redirect requests.
- Redirect requests are branch, jump and jump-register.
- Sits between the PC register, the instruction cache interface and the hazard/branch logic.
- Holds redirects that arrive during an instruction-memory wait, flushes the IF/ID latch on redirect, and parks the front end on halt.

---
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control side of the program counter.
// Produces pc_next / PCen / stall from the current pc, the instruction-memory
// handshake and the redirect requests (jr > jump > branch). A redirect that
// arrives while the front end is held is remembered and applied on the next
// advance. Optional performance counters are built when FETCH_SEQ_PERF_EN is
// defined.
`timescale 1ns/1ps

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        CLK,
    input  logic        nRST,          // active-high asynchronous reset
    input  logic [31:0] pc,
    input  logic        ihit,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt,
`ifdef FETCH_SEQ_PERF_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] redirect_cnt,
`endif
    output logic        PCen,
    output logic [31:0] pc_next,
    output logic        stall,
    output logic        iREN,
    output logic [31:0] imemaddr,
    output logic        flush
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  state, state_next;
    logic        pend_valid, pend_valid_next;
    logic [31:0] pend_target, pend_target_next;

    logic        req_valid;
    logic [31:0] req_target;
    logic        eff_valid;
    logic [31:0] eff_target;
    logic        advance;

    // Redirect request selection and the target used when the PC advances.
    always_comb begin
        req_valid = jr | jump | branch_taken;
        if (jr) begin
            req_target = jr_target;
        end else if (jump) begin
            req_target = jump_target;
        end else begin
            req_target = branch_target;
        end
        // Fetch addresses are word aligned.
        req_target = req_target & 32'hFFFF_FFFC;
        eff_valid  = req_valid | pend_valid;
        eff_target = req_valid ? req_target : pend_target;
        advance    = ihit & ~hazard_stall;
    end

    // Output decode, next state and pending-redirect capture.
    always_comb begin
        PCen             = 1'b0;
        pc_next          = pc;
        stall            = 1'b1;
        iREN             = 1'b0;
        flush            = 1'b0;
        state_next       = state;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        case (state)
            BOOT: begin
                pc_next    = RESET_PC;
                state_next = FETCH;
            end
            FETCH: begin
                iREN = 1'b1;
                if (advance) begin
                    PCen  = 1'b1;
                    stall = 1'b0;
                    if (eff_valid) begin
                        pc_next         = eff_target;
                        flush           = 1'b1;
                        pend_valid_next = 1'b0;
                    end else begin
                        pc_next = pc + PC_STEP;
                    end
                end else if (req_valid) begin
                    // Newest request wins over any older held one.
                    pend_valid_next  = 1'b1;
                    pend_target_next = req_target;
                end
                if (halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign imemaddr = pc;

    // State and pending-redirect registers.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state       <= BOOT;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            state       <= state_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    // Performance counters; PCen and flush are both 0 in HALTED, so they freeze there.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            fetch_cnt    <= 32'h0;
            redirect_cnt <= 32'h0;
        end else begin
            if (PCen) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (flush) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer: each record is one clock cycle of
// inputs with the hand-computed combinational outputs expected in that cycle.
`timescale 1ns/1ps

module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        ihit = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        halt = 1'b0;
    logic        PCen;
    logic [31:0] pc_next;
    logic        stall;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        flush;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;
`endif

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc           (pc),
        .ihit         (ihit),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .halt         (halt),
`ifdef FETCH_SEQ_PERF_EN
        .fetch_cnt    (fetch_cnt),
        .redirect_cnt (redirect_cnt),
`endif
        .PCen         (PCen),
        .pc_next      (pc_next),
        .stall        (stall),
        .iREN         (iREN),
        .imemaddr     (imemaddr),
        .flush        (flush)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        ihit;
        logic        hs;
        logic [2:0]  rd;     // {jr, jump, branch_taken}
        logic [31:0] t_jr;
        logic [31:0] t_j;
        logic [31:0] t_br;
        logic        halt;
        logic        e_pcen;
        logic [31:0] e_next;
        logic        e_stall;
        logic        e_iren;
        logic        e_flush;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [31:0] p, input logic ih, input logic hs,
                       input logic [2:0] rd, input logic [31:0] t_jr, input logic [31:0] t_j,
                       input logic [31:0] t_br, input logic hl, input logic e_pcen,
                       input logic [31:0] e_next, input logic e_stall, input logic e_iren,
                       input logic e_flush);
        vec_t v;
        v.rst = rst; v.pc = p; v.ihit = ih; v.hs = hs; v.rd = rd;
        v.t_jr = t_jr; v.t_j = t_j; v.t_br = t_br; v.halt = hl;
        v.e_pcen = e_pcen; v.e_next = e_next; v.e_stall = e_stall;
        v.e_iren = e_iren; v.e_flush = e_flush;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        nRST          = v.rst;
        pc            = v.pc;
        ihit          = v.ihit;
        hazard_stall  = v.hs;
        jr            = v.rd[2];
        jump          = v.rd[1];
        branch_taken  = v.rd[0];
        jr_target     = v.t_jr;
        jump_target   = v.t_j;
        branch_target = v.t_br;
        halt          = v.halt;
    endtask

    localparam logic [2:0] NO = 3'b000, BR = 3'b001, JP = 3'b010, JR = 3'b100;

    initial begin
        //   rst pc          ih hs rd  t_jr        t_j         t_br        hl | pcen next         st ir fl
        add(1, 32'h0,        0, 0, NO, 0,          0,          0,          0,   0, 32'h0,        1, 0, 0);
        add(0, 32'h0,        1, 0, NO, 0,          0,          0,          0,   0, 32'h0,        1, 0, 0);
        add(0, 32'h0,        1, 0, NO, 0,          0,          0,          0,   1, 32'h4,        0, 1, 0);
        add(0, 32'h40,       0, 0, NO, 0,          0,          0,          0,   0, 32'h40,       1, 1, 0);
        add(0, 32'h40,       0, 0, NO, 0,          0,          0,          0,   0, 32'h40,       1, 1, 0);
        add(0, 32'h40,       0, 0, NO, 0,          0,          0,          0,   0, 32'h40,       1, 1, 0);
        add(0, 32'h40,       1, 0, NO, 0,          0,          0,          0,   1, 32'h44,       0, 1, 0);
        add(0, 32'h40,       0, 0, BR, 0,          0,          32'h103,    0,   0, 32'h40,       1, 1, 0);
        add(0, 32'h40,       0, 0, NO, 0,          0,          0,          0,   0, 32'h40,       1, 1, 0);
        add(0, 32'h40,       1, 0, NO, 0,          0,          0,          0,   1, 32'h100,      0, 1, 1);
        add(0, 32'h100,      1, 0, NO, 0,          0,          0,          0,   1, 32'h104,      0, 1, 0);
        add(0, 32'h104,      1, 1, NO, 0,          0,          0,          0,   0, 32'h104,      1, 1, 0);
        add(0, 32'h104,      0, 0, JP, 0,          32'h500,    0,          0,   0, 32'h104,      1, 1, 0);
        add(0, 32'h104,      1, 1, BR, 0,          0,          32'h606,    0,   0, 32'h104,      1, 1, 0);
        add(0, 32'h104,      1, 0, NO, 0,          0,          0,          0,   1, 32'h604,      0, 1, 1);
        add(0, 32'h604,      1, 0, NO, 0,          0,          0,          0,   1, 32'h608,      0, 1, 0);
        add(0, 32'h608,      1, 0, 7,  32'h200,    32'h300,    32'h400,    0,   1, 32'h200,      0, 1, 1);
        add(0, 32'h200,      1, 0, 3,  0,          32'h301,    32'h400,    0,   1, 32'h300,      0, 1, 1);
        add(0, 32'h300,      0, 0, BR, 0,          0,          32'h700,    0,   0, 32'h300,      1, 1, 0);
        add(0, 32'h300,      1, 0, JP, 0,          32'h800,    0,          0,   1, 32'h800,      0, 1, 1);
        add(0, 32'h800,      1, 0, NO, 0,          0,          0,          0,   1, 32'h804,      0, 1, 0);
        add(0, 32'hFFFF_FFFC,1, 0, NO, 0,          0,          0,          0,   1, 32'h0,        0, 1, 0);
        add(0, 32'h0,        1, 0, NO, 0,          0,          0,          1,   1, 32'h4,        0, 1, 0);
        add(0, 32'h4,        1, 0, BR, 0,          0,          32'h900,    0,   0, 32'h4,        1, 0, 0);
        add(0, 32'h4,        1, 0, JR, 32'hA00,    0,          0,          0,   0, 32'h4,        1, 0, 0);
        add(1, 32'h4,        0, 0, NO, 0,          0,          0,          0,   0, 32'h0,        1, 0, 0);
        add(0, 32'h0,        0, 0, NO, 0,          0,          0,          0,   0, 32'h0,        1, 0, 0);
        add(0, 32'h0,        0, 0, BR, 0,          0,          32'hB00,    0,   0, 32'h0,        1, 1, 0);
        add(1, 32'h0,        0, 0, NO, 0,          0,          0,          0,   0, 32'h0,        1, 0, 0);
        add(0, 32'h0,        1, 0, NO, 0,          0,          0,          0,   0, 32'h0,        1, 0, 0);
        add(0, 32'h0,        1, 0, NO, 0,          0,          0,          0,   1, 32'h4,        0, 1, 0);
        add(0, 32'h4,        0, 0, NO, 0,          0,          0,          1,   0, 32'h4,        1, 1, 0);
        add(0, 32'h4,        1, 0, JP, 0,          32'hC00,    0,          0,   0, 32'h4,        1, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge CLK);
            chk($sformatf("v%0d.PCen", i),     {31'h0, PCen},  {31'h0, vq[i].e_pcen});
            chk($sformatf("v%0d.pc_next", i),  pc_next,        vq[i].e_next);
            chk($sformatf("v%0d.stall", i),    {31'h0, stall}, {31'h0, vq[i].e_stall});
            chk($sformatf("v%0d.iREN", i),     {31'h0, iREN},  {31'h0, vq[i].e_iren});
            chk($sformatf("v%0d.flush", i),    {31'h0, flush}, {31'h0, vq[i].e_flush});
            chk($sformatf("v%0d.imemaddr", i), imemaddr,       vq[i].pc);
            @(posedge CLK);
            #1;
        end

`ifdef FETCH_SEQ_PERF_EN
        // Five sequential fetches and two redirected fetches after a fresh reset.
        vq.delete();
        add(1, 32'h0, 0, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0, 0, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            add(0, 32'h4 * k, 1, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        add(0, 32'h14, 1, 0, JP, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h80, 1, 0, BR, 0, 0, 32'h90, 0, 0, 0, 0, 0, 0);
        add(0, 32'h90, 0, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(posedge CLK);
            #1;
        end
        chk("perf.fetch_cnt", fetch_cnt, 32'd7);
        chk("perf.redirect_cnt", redirect_cnt, 32'd2);
        nRST = 1'b1;
        #1;
        chk("perf.fetch_cnt_rst", fetch_cnt, 32'd0);
        chk("perf.redirect_cnt_rst", redirect_cnt, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
